// File: rtl/slot_pkg.sv
// Shared types and helpers for the one-hot slot link receiver: FSM states,
// default geometry and the slot-bus classifier.
package slot_pkg;

    localparam int N_SLOTS_DEF = 8;
    localparam int SLOT_W_DEF  = 3;
    localparam int MAX_SLOTS   = 64;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        CLS_ZERO  = 2'd0,
        CLS_HOT   = 2'd1,
        CLS_MULTI = 2'd2
    } slot_kind_t;

    // A bus value is one-hot when clearing its lowest set bit leaves nothing.
    function automatic slot_kind_t classify_kind(input logic [MAX_SLOTS-1:0] bus);
        slot_kind_t kind;
        if (bus == '0)
            kind = CLS_ZERO;
        else if ((bus & (bus - MAX_SLOTS'(1))) == '0)
            kind = CLS_HOT;
        else
            kind = CLS_MULTI;
        return kind;
    endfunction

    // Position of the highest set bit; only meaningful for a HOT sample.
    function automatic int onehot_index(input logic [MAX_SLOTS-1:0] bus);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            if (bus[i])
                idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/slot_counter.sv
// Loadable modulo-N_SLOTS slot counter tracking the transmitter's slot phase.
module slot_counter #(
    parameter int N_SLOTS = 8,
    parameter int SLOT_W  = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LOAD,
    input  logic [SLOT_W-1:0] LOAD_VAL,
    input  logic              INC,
    output logic [SLOT_W-1:0] SLOT
);

    always_ff @(posedge CLK) begin
        if (RST)
            SLOT <= '0;
        else if (LOAD)
            SLOT <= LOAD_VAL;
        else if (INC)
            SLOT <= (SLOT == SLOT_W'(N_SLOTS - 1)) ? '0 : SLOT + SLOT_W'(1);
    end

endmodule

// File: rtl/onehot_slot_deserializer.sv
// Receive end of the one-hot time-slot link: locks to the slot phase, rebuilds
// each N_SLOTS-bit word and flags/counts protocol violations.
module onehot_slot_deserializer
    import slot_pkg::*;
#(
    parameter int N_SLOTS = N_SLOTS_DEF,
    parameter int SLOT_W  = SLOT_W_DEF,
    parameter int ERR_W   = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_SLOTS-1:0] O_8,
    output logic [N_SLOTS-1:0] D_8,
    output logic               VALID,
    output logic               LOCKED,
    output logic               ERR,
    output logic [ERR_W-1:0]   ERR_CNT
);

    state_t             state_reg, state_next;
    logic [N_SLOTS-1:0] acc_reg, acc_next, acc_upd;
    logic [N_SLOTS-1:0] d_reg, d_next;
    logic               frame_ok_reg, frame_ok_next;
    logic               valid_reg, valid_next;
    logic               err_reg, err_next;
    logic [ERR_W-1:0]   err_cnt_reg;

    slot_kind_t         kind;
    logic [SLOT_W-1:0]  hot_p;
    logic [SLOT_W-1:0]  slot;
    logic               load, inc;
    logic               cur_bit, legal, at_last, hot_last;

    assign kind     = classify_kind(MAX_SLOTS'(O_8));
    assign hot_p    = SLOT_W'(onehot_index(MAX_SLOTS'(O_8)));
    assign cur_bit  = (kind == CLS_HOT);
    assign legal    = (kind == CLS_ZERO) || ((kind == CLS_HOT) && (hot_p == slot));
    assign at_last  = (slot == SLOT_W'(N_SLOTS - 1));
    assign hot_last = (hot_p == SLOT_W'(N_SLOTS - 1));

    slot_counter #(
        .N_SLOTS (N_SLOTS),
        .SLOT_W  (SLOT_W)
    ) u_slot_counter (
        .CLK      (CLK),
        .RST      (RST),
        .LOAD     (load),
        .LOAD_VAL (hot_p + SLOT_W'(1)),
        .INC      (inc),
        .SLOT     (slot)
    );

    // Accumulator with the current sample's bit written into the current slot.
    generate
        for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_acc
            assign acc_upd[gi] = (slot == SLOT_W'(gi)) ? cur_bit : acc_reg[gi];
        end
    endgenerate

    // frame_ok marks that the accumulator has been filled from slot 0, so a
    // lock landing exactly on the last slot makes the very next frame usable.
    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        d_next        = d_reg;
        frame_ok_next = frame_ok_reg;
        valid_next    = 1'b0;
        err_next      = 1'b0;
        load          = 1'b0;
        inc           = 1'b0;
        case (state_reg)
            HUNT: begin
                if (kind == CLS_HOT) begin
                    load          = 1'b1;
                    acc_next      = '0;
                    frame_ok_next = hot_last;
                    state_next    = LOCK;
                end else if (kind == CLS_MULTI) begin
                    err_next = 1'b1;
                end
            end
            LOCK: begin
                if (legal) begin
                    inc      = 1'b1;
                    acc_next = acc_upd;
                    if (at_last) begin
                        frame_ok_next = 1'b1;
                        if (frame_ok_reg) begin
                            valid_next = 1'b1;
                            d_next     = acc_upd;
                        end
                    end
                end else if (kind == CLS_HOT) begin
                    err_next      = 1'b1;
                    load          = 1'b1;
                    acc_next      = '0;
                    frame_ok_next = hot_last;
                end else begin
                    err_next      = 1'b1;
                    frame_ok_next = 1'b0;
                    state_next    = HUNT;
                end
            end
            default: state_next = HUNT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= HUNT;
            acc_reg      <= '0;
            d_reg        <= '0;
            frame_ok_reg <= 1'b0;
            valid_reg    <= 1'b0;
            err_reg      <= 1'b0;
            err_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            d_reg        <= d_next;
            frame_ok_reg <= frame_ok_next;
            valid_reg    <= valid_next;
            err_reg      <= err_next;
            if (err_next && (err_cnt_reg != {ERR_W{1'b1}}))
                err_cnt_reg <= err_cnt_reg + ERR_W'(1);
        end
    end

    assign D_8     = d_reg;
    assign VALID   = valid_reg;
    assign LOCKED  = (state_reg == LOCK);
    assign ERR     = err_reg;
    assign ERR_CNT = err_cnt_reg;

endmodule

// File: tb/tb_onehot_slot_deserializer.sv
// Bench for the one-hot slot deserializer: a transmitter model drives slot
// samples and a scoreboard queue holds the words expected on VALID.
module tb_onehot_slot_deserializer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] O_8 = 8'h00;
    logic [7:0] D_8;
    logic       VALID;
    logic       LOCKED;
    logic       ERR;
    logic [7:0] ERR_CNT;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_cnt     = 8'h00;
    logic [7:0] sb_q[$];

    typedef struct {
        logic [7:0] word;
        logic [7:0] exp_d;
    } vec_t;
    vec_t tbl [0:6];

    onehot_slot_deserializer dut (
        .CLK     (CLK),
        .RST     (RST),
        .O_8     (O_8),
        .D_8     (D_8),
        .VALID   (VALID),
        .LOCKED  (LOCKED),
        .ERR     (ERR),
        .ERR_CNT (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] slot_bus(input logic [7:0] word, input int s);
        logic [7:0] b;
        b = 8'h01 << s;
        return word[s] ? b : 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", tag, act, exp);
        end
    endtask

    // One slot sample: drive, clock, then compare registered outputs.
    task automatic step(input logic [7:0] o, input bit exp_valid, input logic [7:0] exp_word,
                        input bit exp_err, input bit exp_locked, input string tag);
        logic [7:0] exp_d;
        O_8 = o;
        if (exp_valid)
            sb_q.push_back(exp_word);
        if (exp_err && exp_cnt != 8'hFF)
            exp_cnt = exp_cnt + 8'd1;
        @(posedge CLK);
        #1;
        vectors++;
        if (VALID === 1'b1) begin
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL %s unexpected_valid: got VALID=1 D_8=%h, required VALID=0", tag, D_8);
            end else begin
                exp_d = sb_q.pop_front();
                chk({tag, " D_8"}, 32'(D_8), 32'(exp_d));
            end
        end else if (exp_valid) begin
            miscompares++;
            $display("FAIL %s missing_valid: got VALID=%b, required VALID=1 D_8=%h", tag, VALID, exp_word);
            void'(sb_q.pop_front());
        end
        chk({tag, " ERR"}, 32'(ERR), 32'(exp_err));
        chk({tag, " LOCKED"}, 32'(LOCKED), 32'(exp_locked));
        chk({tag, " ERR_CNT"}, 32'(ERR_CNT), 32'(exp_cnt));
    endtask

    task automatic send_frame(input logic [7:0] word, input int start, input bit expv);
        for (int s = start; s < 8; s++)
            step(slot_bus(word, s), expv && (s == 7), word, 1'b0, 1'b1, "frame");
        $display("frame word=%h start=%0d valid_expected=%0d D_8=%h", word, start, expv, D_8);
    endtask

    // Frame sent from HUNT: lock happens on the first set bit, no VALID.
    task automatic acquire_frame(input logic [7:0] word);
        bit lk;
        lk = 1'b0;
        for (int s = 0; s < 8; s++) begin
            if (word[s])
                lk = 1'b1;
            step(slot_bus(word, s), 1'b0, 8'h00, 1'b0, lk, "acquire");
        end
        $display("acquire word=%h LOCKED=%b", word, LOCKED);
    endtask

    task automatic do_reset(input logic [7:0] o, input string tag);
        RST = 1'b1;
        O_8 = o;
        @(posedge CLK);
        #1;
        vectors++;
        chk({tag, " D_8"}, 32'(D_8), 32'h0);
        chk({tag, " VALID"}, 32'(VALID), 32'h0);
        chk({tag, " LOCKED"}, 32'(LOCKED), 32'h0);
        chk({tag, " ERR"}, 32'(ERR), 32'h0);
        chk({tag, " ERR_CNT"}, 32'(ERR_CNT), 32'h0);
        RST = 1'b0;
        exp_cnt = 8'h00;
        sb_q.delete();
        $display("reset %s done", tag);
    endtask

    initial begin
        tbl[0] = '{8'hAA, 8'hAA};
        tbl[1] = '{8'hB4, 8'hB4};
        tbl[2] = '{8'h00, 8'h00};
        tbl[3] = '{8'hFF, 8'hFF};
        tbl[4] = '{8'h01, 8'h01};
        tbl[5] = '{8'h80, 8'h80};
        tbl[6] = '{8'h5A, 8'h5A};

        @(posedge CLK);
        do_reset(8'h00, "power_on");

        // Acquire on 8'hAA (first HOT at slot 1), then steady frames.
        acquire_frame(8'hAA);
        send_frame(8'hAA, 0, 1'b1);
        send_frame(8'hAA, 0, 1'b1);

        // Word changes while locked, including all-zero and all-one words.
        for (int i = 0; i < 7; i++) begin
            for (int s = 0; s < 8; s++)
                step(slot_bus(tbl[i].word, s), s == 7, tbl[i].exp_d, 1'b0, 1'b1, "table");
            $display("table[%0d] word=%h D_8=%h", i, tbl[i].word, D_8);
        end

        // Misaligned HOT at slot 2: relock at slot 5, partial frame gives no VALID.
        step(slot_bus(8'hAA, 0), 1'b0, 8'h00, 1'b0, 1'b1, "pre_mis");
        step(slot_bus(8'hAA, 1), 1'b0, 8'h00, 1'b0, 1'b1, "pre_mis");
        step(8'h10, 1'b0, 8'h00, 1'b1, 1'b1, "misalign");
        send_frame(8'hAA, 5, 1'b0);
        send_frame(8'hAA, 0, 1'b1);

        // MULTI while locked drops lock; zeros keep it dropped; next HOT relocks.
        for (int s = 0; s < 4; s++)
            step(slot_bus(8'hB4, s), 1'b0, 8'h00, 1'b0, 1'b1, "pre_multi");
        step(8'h03, 1'b0, 8'h00, 1'b1, 1'b0, "multi");
        for (int k = 0; k < 5; k++)
            step(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "hunt_zero");
        acquire_frame(8'hB4);
        send_frame(8'hB4, 0, 1'b1);

        // Error on the last slot suppresses VALID.
        for (int s = 0; s < 7; s++)
            step(slot_bus(8'hAA, s), 1'b0, 8'h00, 1'b0, 1'b1, "pre_last");
        step(8'h01, 1'b0, 8'h00, 1'b1, 1'b1, "err_at_last");
        send_frame(8'hAA, 1, 1'b0);
        send_frame(8'hAA, 0, 1'b1);

        // Lock acquired on the last slot: the very next frame is complete.
        step(8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, "multi_to_hunt");
        acquire_frame(8'h80);
        send_frame(8'h80, 0, 1'b1);

        // Reset mid-frame at slot 4, then relock.
        for (int s = 0; s < 4; s++)
            step(slot_bus(8'h5A, s), 1'b0, 8'h00, 1'b0, 1'b1, "pre_reset");
        do_reset(slot_bus(8'h5A, 4), "mid_frame");
        acquire_frame(8'hAA);
        send_frame(8'hAA, 0, 1'b1);

        // Error counter saturation.
        for (int k = 0; k < 300; k++)
            step(8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, "saturate");
        vectors++;
        chk("saturate final ERR_CNT", 32'(ERR_CNT), 32'h0000_00FF);
        $display("saturation ERR_CNT=%h", ERR_CNT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
